hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 150 +++++++++++++++
 tb/tb_hazard_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and
// a post-reset hold sequence, with a saturating count of stall cycles.
module hazard_unit #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int RESET_HOLD   = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Dreg1_addr,
  input  logic [REG_AW-1:0] Dreg2_addr,
  input  logic [REG_AW-1:0] Ereg1_addr,
  input  logic [REG_AW-1:0] Ereg2_addr,
  input  logic [REG_AW-1:0] Ewrite_reg_addr,
  input  logic              Ewrite_reg_sig,
  input  logic              Eload_sig,
  input  logic [REG_AW-1:0] Mwrite_reg_addr,
  input  logic              Mwrite_reg_sig,
  input  logic [REG_AW-1:0] Wwrite_reg_addr,
  input  logic              Wwrite_reg_sig,
  input  logic              branch_sig,
  output logic [1:0]        forward1E,
  output logic [1:0]        forward2E,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic [CNT_W-1:0]  stall_count,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    INIT  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam logic [3:0] HOLD_LAST  = 4'(RESET_HOLD - 1);
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_t     fsm_q, fsm_d;
  logic [3:0] hold_q, hold_d;
  logic [2:0] flush_q, flush_d;
  logic       load_use;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] addr,
    input logic              m_we,
    input logic [REG_AW-1:0] m_addr,
    input logic              w_we,
    input logic [REG_AW-1:0] w_addr
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && (addr != '0) && (addr == m_addr))
      sel = 2'b01;
    else if (w_we && (addr != '0) && (addr == w_addr))
      sel = 2'b10;
    return sel;
  endfunction

  assign load_use = Eload_sig && Ewrite_reg_sig && (Ewrite_reg_addr != '0) &&
                    ((Ewrite_reg_addr == Dreg1_addr) || (Ewrite_reg_addr == Dreg2_addr));

  assign state = fsm_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q       <= INIT;
      hold_q      <= '0;
      flush_q     <= '0;
      stall_count <= '0;
    end else begin
      fsm_q   <= fsm_d;
      hold_q  <= hold_d;
      flush_q <= flush_d;
      if (fsm_q == RUN && stallF && stall_count != '1)
        stall_count <= stall_count + 1'b1;
    end
  end

  // Forwarding depends only on addresses/enables, never on branch_sig.
  always_comb begin
    forward1E = 2'b00;
    forward2E = 2'b00;
    if (fsm_q != INIT) begin
      forward1E = fwd_sel(Ereg1_addr, Mwrite_reg_sig, Mwrite_reg_addr,
                          Wwrite_reg_sig, Wwrite_reg_addr);
      forward2E = fwd_sel(Ereg2_addr, Mwrite_reg_sig, Mwrite_reg_addr,
                          Wwrite_reg_sig, Wwrite_reg_addr);
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    hold_d  = hold_q;
    flush_d = flush_q;
    stallF  = 1'b0;
    stallD  = 1'b0;
    flushD  = 1'b0;
    flushE  = 1'b0;
    case (fsm_q)
      INIT: begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushD = 1'b1;
        flushE = 1'b1;
        if (hold_q == HOLD_LAST) begin
          fsm_d  = RUN;
          hold_d = '0;
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      RUN: begin
        // Branch wins over load-use: the stalled instruction is squashed anyway.
        if (branch_sig) begin
          flushD = 1'b1;
          flushE = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            fsm_d   = FLUSH;
            flush_d = FLUSH_LAST;
          end
        end else if (load_use) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end
      FLUSH: begin
        flushD = 1'b1;
        flushE = 1'b1;
        if (branch_sig) begin
          flush_d = FLUSH_LAST;
        end else begin
          flush_d = flush_q - 3'd1;
          if (flush_q == 3'd1)
            fsm_d = RUN;
        end
      end
      default: begin
        fsm_d   = INIT;
        hold_d  = '0;
        flush_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized bench for hazard_unit: two instances (3-cycle flush with 2-bit
// counter, and defaults) checked against a cycle-level behavioural model.
module tb_hazard_unit;

  localparam int RH = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d1, d2, e1, e2, ew, mw, ww;
  logic       ewe, eld, mwe, wwe, br;

  logic [1:0]  a_f1, a_f2, a_st, b_f1, b_f2, b_st;
  logic        a_sF, a_sD, a_fD, a_fE, b_sF, b_sD, b_fD, b_fE;
  logic [1:0]  a_sc;
  logic [15:0] b_sc;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Model state per instance: remaining INIT cycles, pending extra flush
  // cycles after the current one, and the stall tally.
  int fc[2]       = '{3, 1};
  int cmax[2]     = '{3, 65535};
  int init_left[2];
  int extra[2];
  int stalls[2];

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(5), .FLUSH_CYCLES(3), .RESET_HOLD(RH), .CNT_W(2)) u_a (
    .clk(clk), .reset(reset),
    .Dreg1_addr(d1), .Dreg2_addr(d2), .Ereg1_addr(e1), .Ereg2_addr(e2),
    .Ewrite_reg_addr(ew), .Ewrite_reg_sig(ewe), .Eload_sig(eld),
    .Mwrite_reg_addr(mw), .Mwrite_reg_sig(mwe),
    .Wwrite_reg_addr(ww), .Wwrite_reg_sig(wwe), .branch_sig(br),
    .forward1E(a_f1), .forward2E(a_f2), .stallF(a_sF), .stallD(a_sD),
    .flushD(a_fD), .flushE(a_fE), .stall_count(a_sc), .state(a_st)
  );

  hazard_unit #(.REG_AW(5), .FLUSH_CYCLES(1), .RESET_HOLD(RH), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset),
    .Dreg1_addr(d1), .Dreg2_addr(d2), .Ereg1_addr(e1), .Ereg2_addr(e2),
    .Ewrite_reg_addr(ew), .Ewrite_reg_sig(ewe), .Eload_sig(eld),
    .Mwrite_reg_addr(mw), .Mwrite_reg_sig(mwe),
    .Wwrite_reg_addr(ww), .Wwrite_reg_sig(wwe), .branch_sig(br),
    .forward1E(b_f1), .forward2E(b_f2), .stallF(b_sF), .stallD(b_sD),
    .flushD(b_fD), .flushE(b_fE), .stall_count(b_sc), .state(b_st)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_fwd(input logic [4:0] a);
    if (mwe && a != 0 && a == mw) return 1;
    if (wwe && a != 0 && a == ww) return 2;
    return 0;
  endfunction

  function automatic bit ref_load_use();
    return eld && ewe && ew != 0 && (ew == d1 || ew == d2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      init_left[i] = RH;
      extra[i]     = 0;
      stalls[i]    = 0;
    end
  endtask

  task automatic check_inst(input int i, input string nm,
                            input logic [1:0] f1, input logic [1:0] f2,
                            input logic sF, input logic sD, input logic fD, input logic fE,
                            input logic [31:0] sc, input logic [1:0] st);
    int est, ef1, ef2, esF, esD, efD, efE;
    if (init_left[i] > 0) begin
      est = 0; ef1 = 0; ef2 = 0; esF = 1; esD = 1; efD = 1; efE = 1;
    end else begin
      est = (extra[i] > 0) ? 2 : 1;
      ef1 = ref_fwd(e1);
      ef2 = ref_fwd(e2);
      if (extra[i] > 0 || br) begin
        esF = 0; esD = 0; efD = 1; efE = 1;
      end else if (ref_load_use()) begin
        esF = 1; esD = 1; efD = 0; efE = 1;
      end else begin
        esF = 0; esD = 0; efD = 0; efE = 0;
      end
    end
    check({nm, ".state"},  32'(st), 32'(est));
    check({nm, ".fwd1"},   32'(f1), 32'(ef1));
    check({nm, ".fwd2"},   32'(f2), 32'(ef2));
    check({nm, ".stallF"}, 32'(sF), 32'(esF));
    check({nm, ".stallD"}, 32'(sD), 32'(esD));
    check({nm, ".flushD"}, 32'(fD), 32'(efD));
    check({nm, ".flushE"}, 32'(fE), 32'(efE));
    check({nm, ".stall_count"}, sc, 32'(stalls[i]));
    // advance to the state after the coming clock edge
    if (init_left[i] > 0) begin
      init_left[i]--;
    end else begin
      if (est == 1 && esF == 1 && stalls[i] < cmax[i]) stalls[i]++;
      if (br) extra[i] = fc[i] - 1;
      else if (extra[i] > 0) extra[i]--;
    end
  endtask

  // Called just after a rising edge; inputs already driven.
  task automatic step();
    @(negedge clk);
    check_inst(0, "A", a_f1, a_f2, a_sF, a_sD, a_fD, a_fE, 32'(a_sc), a_st);
    check_inst(1, "B", b_f1, b_f2, b_sF, b_sD, b_fD, b_fE, 32'(b_sc), b_st);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {d1, d2, e1, e2, ew, mw, ww} = '0;
    {ewe, eld, mwe, wwe, br} = '0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    eld = 1'b1; ewe = 1'b1; ew = r; d2 = r;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #1;
    check("rst.A.state",  32'(a_st), 32'd0);
    check("rst.A.stallF", 32'(a_sF), 32'd1);
    check("rst.A.flushD", 32'(a_fD), 32'd1);
    check("rst.A.flushE", 32'(a_fE), 32'd1);
    check("rst.A.count",  32'(a_sc), 32'd0);
    check("rst.B.state",  32'(b_st), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // hold sequence after release
    repeat (RH) step();
    // M beats W on operand 1; register 0 never forwards
    e1 = 5; mw = 5; mwe = 1; ww = 5; wwe = 1; e2 = 0;
    step();
    clear_inputs();
    // single load-use bubble
    set_load_use(7);
    step();
    clear_inputs();
    step();
    // branch pulse, then a pulse restarting the flush on the second cycle
    br = 1; step(); br = 0;
    repeat (3) step();
    br = 1; step(); br = 1; step(); br = 0;
    repeat (4) step();
    // branch and load-use together
    set_load_use(9); br = 1;
    step();
    clear_inputs();
    repeat (3) step();
    // saturation of the narrow counter
    set_load_use(4);
    repeat (5) step();
    clear_inputs();
    // reset while flushing
    br = 1; step(); br = 0;
    step();
    pulse_reset();
    repeat (RH + 1) step();

    for (int n = 0; n < 600; n++) begin
      d1  = 5'($urandom_range(0, 7));
      d2  = 5'($urandom_range(0, 7));
      e1  = 5'($urandom_range(0, 7));
      e2  = 5'($urandom_range(0, 7));
      ew  = 5'($urandom_range(0, 7));
      mw  = 5'($urandom_range(0, 7));
      ww  = 5'($urandom_range(0, 7));
      ewe = 1'($urandom_range(0, 3) != 0);
      eld = 1'($urandom_range(0, 2) == 0);
      mwe = 1'($urandom_range(0, 1));
      wwe = 1'($urandom_range(0, 1));
      br  = 1'($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 149) == 0) pulse_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
